// File: rtl/mio_bus_pkg.sv
// Shared encodings for the MIO bus arbiter: FSM states and bus-owner IDs.
package mio_bus_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mio_rr_pick.sv
// Combinational two-way grant pick between the CPU and DMA masters.
module mio_rr_pick
    import mio_bus_pkg::*;
#(
    parameter int CPU_PRIORITY = 0
) (
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_owner = OWN_CPU;
        if (cpu_req && dma_req) begin
            // On a tie, round-robin hands the bus to whoever did not have it last.
            grant_owner = (CPU_PRIORITY != 0) ? OWN_CPU : ~last_owner;
        end else if (dma_req) begin
            grant_owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Serialises CPU and DMA accesses onto one memory/MIO port, one transaction at a time.
// state    | meaning
// S_IDLE   | sample requests, grant and latch the winning master's command
// S_ACCESS | mem_en pulse in first cycle, wait MEM_LAT cycles, capture read data
// S_DONE   | one-cycle ready pulse to the owner, record last_owner
module mio_bus_arbiter
    import mio_bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mio_bus_arbiter: MEM_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              dma_ready_q, dma_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_valid, grant_owner;

    mio_rr_pick #(.CPU_PRIORITY(CPU_PRIORITY)) u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_owner (last_owner_q),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWN_DMA;
            we_q         <= 1'b0;
            owner_q      <= OWN_CPU;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            cpu_ready_q  <= cpu_ready_d;
            dma_ready_q  <= dma_ready_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d = S_ACCESS;
                    cnt_d   = LAT_INIT;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE: begin
                state_d      = S_IDLE;
                last_owner_d = owner_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ready_d = 1'b0;
        dma_ready_d = 1'b0;
        we_d        = we_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    mem_en_d = 1'b1;
                    owner_d  = grant_owner;
                    we_d     = (grant_owner == OWN_CPU) ? cpu_we    : dma_we;
                    addr_d   = (grant_owner == OWN_CPU) ? cpu_addr  : dma_addr;
                    wdata_d  = (grant_owner == OWN_CPU) ? cpu_wdata : dma_wdata;
                    mem_we_d = we_d;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) rdata_d = mem_rdata;
                    cpu_ready_d = (owner_q == OWN_CPU);
                    dma_ready_d = (owner_q == OWN_DMA);
                end
            end
            default: ;
        endcase
    end

    assign cpu_ready = cpu_ready_q;
    assign dma_ready = dma_ready_q;
    assign cpu_rdata = rdata_q;
    assign dma_rdata = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
Shares the single data-memory/MIO port between the CPU data port (Addr_out/Data_out/MemRW/CPU_MIO side) and a second master (debug/DMA loader). It serialises one transaction at a time, drives the memory, and returns a one-cycle ready pulse. The CPU stalls on that pulse through its MIO_ready input. It sits between the CPU top and data RAM/peripheral bus.

Parameters:
ADDR_W, 32, address width of both masters and memory
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15; 0 is an elaboration error
CPU_PRIORITY, 0, 1 = CPU always wins ties; 0 = round-robin on ties

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
cpu_req  in  1  CPU requests access
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  one-cycle completion pulse to CPU (feeds MIO_ready)
cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
dma_req / dma_we / dma_addr / dma_wdata  in  1/1/ADDR_W/DATA_W  second master, same meaning
dma_ready  out  1  completion pulse to second master
dma_rdata  out  DATA_W  read data, valid while dma_ready=1
mem_en  out  1  memory strobe, one cycle per transaction
mem_we  out  1  memory write enable, asserted only together with mem_en
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in every state except IDLE
owner  out  1  0=CPU, 1=DMA; current or last granted master

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Registered outputs throughout.
- Reset (rst=0, async): state=IDLE, all outputs 0, last_owner=DMA, wait counter 0. Mid-transaction reset aborts the transaction: no ready pulse, mem_en drops immediately.
- IDLE: samples requests.
  - Only one req high: grant it.
  - Both high, CPU_PRIORITY=1: grant CPU.
  - Both high, CPU_PRIORITY=0: grant the master that is not last_owner.
  - On grant, latch we/addr/wdata/owner and go to ACCESS with counter=MEM_LAT-1.
- ACCESS: mem_en=1 in the first cycle only; mem_we=we_reg in that same cycle. mem_addr/mem_wdata hold their latched values.
  - Counter decrements each cycle. When it reaches 0 (the last ACCESS cycle), capture mem_rdata into rdata_reg if the transaction is a read, then go to DONE.
- DONE: the owner's ready=1 for exactly one cycle. The other master's ready stays 0. Update last_owner, then go to IDLE unconditionally. Requests are not sampled in DONE.
- Latency: req first high at cycle N (state IDLE) → mem_en at N+1 → ready at N+1+MEM_LAT. Reads and writes have identical timing. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Masters hold req until ready. A req dropped mid-transaction does not cancel it; the ready pulse is still issued.
- cpu_rdata/dma_rdata both show rdata_reg. It is updated only on reads and otherwise holds its value.
- A losing master keeps waiting. In round-robin mode a continuously requesting master waits at most one transaction.
- mem_addr/mem_wdata hold their last value in IDLE and change only on grant.

Decomposition:
- Shared package mio_bus_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_ACCESS=2'd1, S_DONE=2'd2
  - owner constants: OWN_CPU=1'b0, OWN_DMA=1'b1
- One sub-module, mio_rr_pick: combinational two-way pick from (cpu_req, dma_req, last_owner, CPU_PRIORITY), returning grant_valid and grant_owner.
- The FSM, counter and latches live in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both reqs high → all outputs 0, busy=0, no mem_en; release → CPU granted first.
- CPU read, MEM_LAT=1: cpu_req at cycle 0 with addr=0x100, mem returns 0xDEADBEEF → mem_en=1 at cycle 1 with mem_addr=0x100, mem_we=0; cpu_ready=1 at cycle 2 with cpu_rdata=0xDEADBEEF; dma_ready stays 0.
- DMA write, MEM_LAT=3: dma_we=1, addr=0x20, wdata=0x55AA → single mem_en/mem_we pulse at cycle 1 with mem_wdata=0x55AA; dma_ready at cycle 4; owner=1.
- Tie, round-robin: both reqs held high for 4 transactions → grants alternate CPU, DMA, CPU, DMA; each ready is a single-cycle pulse, MEM_LAT+2 cycles apart.
- Tie, CPU_PRIORITY=1: both reqs high → CPU granted every time; DMA granted only once cpu_req drops.
- Abort: assert rst=0 during ACCESS with MEM_LAT=4 → mem_en=0 and no ready pulse; after release, a fresh request completes normally.
